// File: rtl/fp_norm_pkg.sv
// Shared types for the post-addition normalization pipeline: stage-1 payload,
// output record and default datapath widths.
package fp_norm_pkg;

  localparam int unsigned FP_NORM_WIDTH = 24;
  localparam int unsigned FP_NORM_EXP_W = 8;
  localparam int unsigned FP_NORM_WLOG  = $clog2(FP_NORM_WIDTH);

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } fp_norm_dir_e;

  // exp holds the already-adjusted exponent; zero/unf/ovf are decided in stage 1
  typedef struct packed {
    logic                      sgn;
    logic [FP_NORM_EXP_W-1:0]  exp;
    logic [FP_NORM_WIDTH-1:0]  mag;
    fp_norm_dir_e              dir;
    logic [FP_NORM_WLOG-1:0]   lsh;
    logic                      zero;
    logic                      unf;
    logic                      ovf;
  } fp_norm_s1_t;

  typedef struct packed {
    logic                      sgn;
    logic [FP_NORM_EXP_W-1:0]  exp;
    logic [FP_NORM_WIDTH-2:0]  man;
    logic                      sticky;
    logic                      zero;
    logic                      unf;
    logic                      ovf;
  } fp_norm_out_t;

endpackage

// File: rtl/fp_norm_shifter.sv
// Combinational normalization shifter: left by i_lsh (zero fill) or right by one
// with the dropped bit returned as sticky.
module fp_norm_shifter #(
  parameter  int unsigned WIDTH     = 24,
  localparam int unsigned WIDTH_LOG = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]     i_mag,
  input  logic                 i_dir_right,
  input  logic [WIDTH_LOG-1:0] i_lsh,
  output logic [WIDTH-2:0]     o_man,
  output logic                 o_sticky
);

  logic [WIDTH-2:0] w_shl;

  // The carry bit is always clear on the left path, so it is not shifted.
  assign w_shl = i_mag[WIDTH-2:0] << i_lsh;

  always_comb begin
    o_man    = '0;
    o_sticky = 1'b0;
    if (i_dir_right) begin
      o_man    = i_mag[WIDTH-1:1];
      o_sticky = i_mag[0];
    end else begin
      o_man    = w_shl;
    end
  end

endmodule

// File: rtl/fp_normalize_pipe.sv
// Two-stage valid/ready normalization stage of the FP adder.
// Define FP_NORMALIZE_PIPE_ASSERT_EN to compile in interface assertions.
module fp_normalize_pipe
  import fp_norm_pkg::*;
#(
  parameter  int unsigned WIDTH     = FP_NORM_WIDTH,
  parameter  int unsigned EXP_W     = FP_NORM_EXP_W,
  localparam int unsigned WIDTH_LOG = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic                 Sum_sgn,
  input  logic [EXP_W-1:0]     Sum_exp,
  input  logic [WIDTH-1:0]     Sum_mag,
  input  logic [WIDTH_LOG-1:0] msb_pos,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic                 norm_sgn,
  output logic [EXP_W-1:0]     norm_exp,
  output logic [WIDTH-2:0]     norm_man,
  output logic                 norm_sticky,
  output logic                 norm_zero,
  output logic                 norm_unf,
  output logic                 norm_ovf
);

  localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

  logic         r_v1, r_v2;
  fp_norm_s1_t  r_s1;
  fp_norm_out_t r_out;

  logic           w_s1_rdy, w_s2_rdy;
  logic           w_zero, w_right;
  logic [WIDTH_LOG-1:0] w_lsh;
  logic [EXP_W:0] w_exp_ext, w_lsh_ext, w_exp_adj;
  fp_norm_s1_t    w_s1;
  fp_norm_out_t   w_out;
  logic [WIDTH-2:0] w_man;
  logic           w_sticky;

  assign w_s2_rdy = !r_v2 || out_rdy;
  assign w_s1_rdy = !r_v1 || w_s2_rdy;
  assign in_rdy   = w_s1_rdy;

  // Stage 1: direction, shift amount, adjusted exponent and flag decisions
  assign w_zero    = (Sum_mag == '0);
  assign w_right   = (msb_pos == WIDTH_LOG'(WIDTH-1));
  assign w_lsh     = w_right ? '0 : (WIDTH_LOG'(WIDTH-2) - msb_pos);
  assign w_exp_ext = {1'b0, Sum_exp};
  assign w_lsh_ext = (EXP_W+1)'(w_lsh);
  assign w_exp_adj = w_right ? (w_exp_ext + 1'b1) : (w_exp_ext - w_lsh_ext);

  always_comb begin
    w_s1      = '0;
    w_s1.sgn  = Sum_sgn;
    w_s1.exp  = w_exp_adj[EXP_W-1:0];
    w_s1.mag  = Sum_mag;
    w_s1.dir  = w_right ? DIR_RIGHT : DIR_LEFT;
    w_s1.lsh  = w_lsh;
    w_s1.zero = w_zero;
    w_s1.unf  = !w_zero && !w_right && (w_exp_ext <= w_lsh_ext);
    w_s1.ovf  = !w_zero && w_right && (w_exp_adj >= EXP_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_s1 <= '0;
    end else if (w_s1_rdy) begin
      r_v1 <= in_vld;
      if (in_vld) r_s1 <= w_s1;
    end
  end

  // Stage 2: shift, then flush or saturate
  fp_norm_shifter #(.WIDTH(WIDTH)) u_shifter (
    .i_mag       (r_s1.mag),
    .i_dir_right (r_s1.dir == DIR_RIGHT),
    .i_lsh       (r_s1.lsh),
    .o_man       (w_man),
    .o_sticky    (w_sticky)
  );

  always_comb begin
    w_out      = '0;
    w_out.sgn  = r_s1.sgn;
    w_out.zero = r_s1.zero;
    w_out.unf  = r_s1.unf;
    w_out.ovf  = r_s1.ovf;
    if (r_s1.ovf) begin
      w_out.exp = '1;
    end else if (!r_s1.zero && !r_s1.unf) begin
      w_out.exp    = r_s1.exp;
      w_out.man    = w_man;
      w_out.sticky = w_sticky;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v2  <= 1'b0;
      r_out <= '0;
    end else if (w_s2_rdy) begin
      r_v2 <= r_v1;
      if (r_v1) r_out <= w_out;
    end
  end

  assign out_vld     = r_v2;
  assign norm_sgn    = r_out.sgn;
  assign norm_exp    = r_out.exp;
  assign norm_man    = r_out.man;
  assign norm_sticky = r_out.sticky;
  assign norm_zero   = r_out.zero;
  assign norm_unf    = r_out.unf;
  assign norm_ovf    = r_out.ovf;

`ifdef FP_NORMALIZE_PIPE_ASSERT_EN
  a_msb_pos: assert property (@(posedge clk) disable iff (rst)
    (in_vld && in_rdy && (Sum_mag != '0)) |-> ((Sum_mag >> msb_pos) == WIDTH'(1)))
    else $error("msb_pos does not match leading one of Sum_mag");

  a_in_stable: assert property (@(posedge clk) disable iff (rst)
    (in_vld && !in_rdy) |=> (in_vld && $stable({Sum_sgn, Sum_exp, Sum_mag, msb_pos})))
    else $error("input changed while stalled");

  a_out_vld_known: assert property (@(posedge clk) disable iff (rst)
    !$isunknown(out_vld))
    else $error("out_vld unknown after reset");
`else
`endif

endmodule

// File: tb/tb_fp_normalize_pipe.sv
// Directed bench for fp_normalize_pipe with a behavioural normalization model
// and a per-cycle output scoreboard.
module tb_fp_normalize_pipe;

  logic        clk, rst;
  logic        in_vld, in_rdy, out_vld, out_rdy;
  logic        Sum_sgn;
  logic [7:0]  Sum_exp;
  logic [23:0] Sum_mag;
  logic [4:0]  msb_pos;
  logic        norm_sgn, norm_sticky, norm_zero, norm_unf, norm_ovf;
  logic [7:0]  norm_exp;
  logic [22:0] norm_man;

  int total = 0;
  int bad = 0;
  int accepts = 0;
  int stalls = 0;
  logic [35:0] q[$];

  fp_normalize_pipe #(.WIDTH(24), .EXP_W(8)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy),
    .Sum_sgn(Sum_sgn), .Sum_exp(Sum_exp), .Sum_mag(Sum_mag), .msb_pos(msb_pos),
    .out_vld(out_vld), .out_rdy(out_rdy),
    .norm_sgn(norm_sgn), .norm_exp(norm_exp), .norm_man(norm_man),
    .norm_sticky(norm_sticky), .norm_zero(norm_zero), .norm_unf(norm_unf),
    .norm_ovf(norm_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [35:0] pk(bit s, int e, logic [22:0] m, bit st, bit z, bit u, bit o);
    logic [7:0] e8;
    e8 = e[7:0];
    return {s, e8, m, st, z, u, o};
  endfunction

  // Normalize by repeated single-bit shifting until the hidden 1 lands at bit 22.
  function automatic logic [35:0] model(bit s, int e, logic [23:0] mag);
    logic [23:0] m;
    int ee;
    if (mag == 0) return pk(s, 0, 0, 0, 1, 0, 0);
    if (mag[23]) begin
      ee = e + 1;
      if (ee >= 255) return pk(s, 255, 0, 0, 0, 0, 1);
      m = mag >> 1;
      return pk(s, ee, m[22:0], mag[0], 0, 0, 0);
    end
    m = mag;
    ee = e;
    while (!m[22]) begin
      m = m << 1;
      ee = ee - 1;
    end
    if (ee <= 0) return pk(s, 0, 0, 0, 0, 1, 0);
    return pk(s, ee, m[22:0], 0, 0, 0, 0);
  endfunction

  function automatic logic [4:0] lead(logic [23:0] mag);
    for (int i = 23; i >= 0; i--) if (mag[i]) return 5'(i);
    return 5'd7;
  endfunction

  function automatic logic [35:0] act();
    return {norm_sgn, norm_exp, norm_man, norm_sticky, norm_zero, norm_unf, norm_ovf};
  endfunction

  task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, a, e);
    end
  endtask

  // Scoreboard: compare every valid output cycle, record every input transfer.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_vld) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_out actual=%h required=none", act());
        end else begin
          chk("out_data", 64'(act()), 64'(q[0]));
          if (out_rdy) void'(q.pop_front());
        end
      end
      if (in_vld && in_rdy) begin
        q.push_back(model(Sum_sgn, int'(Sum_exp), Sum_mag));
        accepts++;
      end
    end
  end

  task automatic send(bit s, logic [7:0] e, logic [23:0] mag);
    int n;
    in_vld  = 1'b1;
    Sum_sgn = s;
    Sum_exp = e;
    Sum_mag = mag;
    msb_pos = lead(mag);
    n = 0;
    @(negedge clk);
    while (!in_rdy && n < 50) begin
      stalls++;
      n++;
      @(negedge clk);
    end
    if (n >= 50) chk("send_timeout", 64'(n), 64'd0);
    @(posedge clk);
    #1;
    in_vld = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    int base;
    rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b1;
    Sum_sgn = 1'b0; Sum_exp = '0; Sum_mag = '0; msb_pos = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_vld", 64'(out_vld), 64'd0);
    chk("rst_in_rdy", 64'(in_rdy), 64'd1);
    chk("rst_outputs", 64'(act()), 64'd0);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    // Pin the model against hand-derived results
    chk("model_rsh", 64'(model(0, 100, 24'h800001)), 64'(pk(0, 101, 23'h400000, 1, 0, 0, 0)));
    chk("model_lsh", 64'(model(0, 100, 24'h000001)), 64'(pk(0, 78, 23'h400000, 0, 0, 0, 0)));
    chk("model_unf", 64'(model(0, 22, 24'h000001)), 64'(pk(0, 0, 0, 0, 0, 1, 0)));
    chk("model_zero", 64'(model(1, 50, 24'h000000)), 64'(pk(1, 0, 0, 0, 1, 0, 0)));
    chk("model_ovf", 64'(model(0, 254, 24'hC00000)), 64'(pk(0, 255, 0, 0, 0, 0, 1)));

    // Directed vectors, including the boundary cases
    send(0, 8'd100, 24'h800001);
    send(0, 8'd100, 24'h000001);
    send(0, 8'd22,  24'h000001);
    send(0, 8'd23,  24'h000001);
    send(1, 8'd50,  24'h000000);
    send(0, 8'd254, 24'hC00000);
    send(1, 8'd253, 24'hFFFFFF);
    send(1, 8'd127, 24'h400000);
    send(0, 8'd40,  24'h00ABCD);
    send(0, 8'd21,  24'h000003);
    send(0, 8'd255, 24'h5A5A5A);
    drain();

    // Throughput: back-to-back with out_rdy high must never stall
    stalls = 0;
    for (int i = 0; i < 8; i++) send(i[0], 8'(60 + i), 24'h1 << (3 * i));
    chk("burst_stalls", 64'(stalls), 64'd0);
    drain();

    // Backpressure: two buffered then in_rdy low; release pushes and pops together
    out_rdy = 1'b0;
    base = accepts;
    fork
      begin
        send(0, 8'd10, 24'h000100);
        send(1, 8'd11, 24'h020000);
        send(0, 8'd12, 24'h800002);
        send(1, 8'd13, 24'h003000);
      end
      begin
        repeat (3) @(negedge clk);
        #1;
        chk("bp_accepts", 64'(accepts - base), 64'd2);
        chk("bp_in_rdy_low", 64'(in_rdy), 64'd0);
        @(posedge clk); #1;
        out_rdy = 1'b1;
        #1;
        chk("bp_in_rdy_pop", 64'(in_rdy), 64'd1);
      end
    join
    drain();
    chk("bp_total", 64'(accepts - base), 64'd4);

    // Asynchronous reset with two transactions in flight
    send(0, 8'd90, 24'h000F00);
    send(1, 8'd91, 24'h00F000);
    #1;
    chk("pre_rst_vld", 64'(out_vld), 64'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_vld", 64'(out_vld), 64'd0);
    chk("async_rst_rdy", 64'(in_rdy), 64'd1);
    q.delete();
    @(negedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    send(0, 8'd5, 24'h000010);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
